// File: rtl/alu_issue.sv
// Issue front-end for the divided-strobe ALU: decodes a MIPS word, holds operands
// across at least one ALU evaluation, then returns the captured result with tags.
module alu_issue #(
    parameter int          HOLD_CYCLES = 8,
    parameter logic [5:0]  ED_IDLE     = 6'b110110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_ed,
    input  logic [31:0] alu_c,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_dst,
    output logic [1:0]  res_kind,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;

    logic [31:0] dec_a_s;
    logic [31:0] dec_b_s;
    logic [5:0]  dec_ed_s;
    logic [4:0]  dec_dst_s;
    logic [1:0]  dec_kind_s;
    logic        dec_ill_s;
    logic [31:0] simm_s;
    logic [31:0] zimm_s;
    logic [5:0]  funct_s;
    logic        unused_s;

    assign funct_s  = instr[5:0];
    assign simm_s   = {{16{instr[15]}}, instr[15:0]};
    assign zimm_s   = {16'd0, instr[15:0]};
    assign in_ready = (state_r == S_IDLE);
    // The rs field is only needed by the register file, which supplies rs_val.
    assign unused_s = ^instr[25:21];

    // Instruction decode: operands, opcode, destination and kind for one word.
    always_comb begin
        dec_a_s    = rs_val;
        dec_b_s    = rt_val;
        dec_ed_s   = ED_IDLE;
        dec_dst_s  = instr[20:16];
        dec_kind_s = 2'd0;
        dec_ill_s  = 1'b0;
        case (instr[31:26])
            6'b000000: begin
                dec_ed_s  = funct_s;
                dec_dst_s = instr[15:11];
                case (funct_s)
                    6'b000000, 6'b000010, 6'b000011: begin
                        dec_a_s = rt_val;
                        dec_b_s = {27'd0, instr[10:6]};
                    end
                    6'b000100, 6'b000110, 6'b000111: begin
                        dec_a_s = rt_val;
                        dec_b_s = {27'd0, rs_val[4:0]};
                    end
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011, 6'b010000, 6'b010010: dec_kind_s = 2'd0;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010001, 6'b010011: dec_kind_s = 2'd3;
                    default: begin
                        dec_ill_s = 1'b1;
                        dec_ed_s  = ED_IDLE;
                    end
                endcase
            end
            6'b001000, 6'b001001: begin dec_ed_s = 6'b110000; dec_b_s = simm_s; end
            6'b001010, 6'b001011: begin dec_ed_s = 6'b110101; dec_b_s = simm_s; end
            6'b001100: begin dec_ed_s = 6'b110010; dec_b_s = zimm_s; end
            6'b001101: begin dec_ed_s = 6'b110011; dec_b_s = zimm_s; end
            6'b001110: begin dec_ed_s = 6'b110100; dec_b_s = zimm_s; end
            6'b001111: begin dec_ed_s = 6'b110111; dec_b_s = {instr[15:0], 16'd0}; end
            6'b100011, 6'b101011: begin
                dec_ed_s   = 6'b110000;
                dec_b_s    = simm_s;
                dec_kind_s = 2'd2;
            end
            6'b000100: begin dec_ed_s = 6'b111100; dec_kind_s = 2'd1; end
            6'b000101: begin dec_ed_s = 6'b111101; dec_kind_s = 2'd1; end
            6'b000110: begin dec_ed_s = 6'b111110; dec_b_s = 32'd0; dec_kind_s = 2'd1; end
            6'b000111: begin dec_ed_s = 6'b111111; dec_b_s = 32'd0; dec_kind_s = 2'd1; end
            6'b000001: begin
                dec_b_s    = 32'd0;
                dec_kind_s = 2'd1;
                case (instr[20:16])
                    5'd0:    dec_ed_s  = 6'b111000;
                    5'd1:    dec_ed_s  = 6'b111001;
                    default: dec_ill_s = 1'b1;
                endcase
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = dec_ill_s ? S_RESP : S_HOLD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Operand, hold counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 8'd0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_ed    <= ED_IDLE;
            res_valid <= 1'b0;
            res_data  <= 32'd0;
            res_dst   <= 5'd0;
            res_kind  <= 2'd3;
            illegal   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && dec_ill_s) begin
                        illegal   <= 1'b1;
                        res_kind  <= 2'd3;
                        res_data  <= 32'd0;
                        res_dst   <= 5'd0;
                        res_valid <= 1'b1;
                    end else if (in_valid) begin
                        alu_a    <= dec_a_s;
                        alu_b    <= dec_b_s;
                        alu_ed   <= dec_ed_s;
                        res_dst  <= dec_dst_s;
                        res_kind <= dec_kind_s;
                        cnt_r    <= CNT_LOAD;
                    end
                end
                S_HOLD: begin
                    // Operands have been stable long enough to span an ALU strobe.
                    if (cnt_r == 8'd0) begin
                        res_data  <= alu_c;
                        alu_ed    <= ED_IDLE;
                        alu_a     <= 32'd0;
                        alu_b     <= 32'd0;
                        res_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a strobed ALU model (one evaluation per 6 clk).
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_ed;
    logic [31:0] alu_c = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [4:0]  res_dst;
    logic [1:0]  res_kind;
    logic        illegal;

    int          vectors = 0;
    int          miscompares = 0;
    int          lat;
    int          div = 0;
    logic        ed_ok;
    logic        flag;
    logic [31:0] a_seen;
    logic [31:0] b_seen;

    localparam logic [5:0] ED_IDLE = 6'b110110;

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ed(alu_ed), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_dst(res_dst), .res_kind(res_kind), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] ed);
        case (ed)
            6'b100000, 6'b100001, 6'b110000: return a + b;
            6'b100010: return a - b;
            6'b000011: return $signed(a) >>> b[4:0];
            6'b110011, 6'b100101: return a | b;
            6'b111100: return {31'd0, a == b};
            6'b111000: return {31'd0, a[31]};
            6'b110110: return a;
            default:   return 32'd0;
        endcase
    endfunction

    // ALU evaluates only on every sixth clock edge.
    always @(posedge clk) begin
        div <= (div == 5) ? 0 : div + 1;
        if (div == 5) alu_c <= alu_model(alu_a, alu_b, alu_ed);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [5:0] ed);
        @(negedge clk);
        instr = i; rs_val = rs; rt_val = rt; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a_seen = alu_a; b_seen = alu_b;
        lat = 0; ed_ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
            if (alu_ed !== ed) ed_ok = 1'b0;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("rel_valid", {31'd0, res_valid}, 32'd0);
        chk("rel_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ed", {26'd0, alu_ed}, {26'd0, ED_IDLE});
        chk("rst_a", alu_a, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_kind", {30'd0, res_kind}, 32'd3);
        chk("rst_data", res_data, 32'd0);
        rst = 1'b0;

        // add $3,$1,$2
        run(32'h00221820, 32'd5, 32'd7, 6'b100000);
        chk("add_lat", lat, 32'd9);
        chk("add_edhold", {31'd0, ed_ok}, 32'd1);
        chk("add_a", a_seen, 32'd5);
        chk("add_b", b_seen, 32'd7);
        chk("add_data", res_data, 32'd12);
        chk("add_dst", {27'd0, res_dst}, 32'd3);
        chk("add_kind", {30'd0, res_kind}, 32'd0);
        chk("add_ill", {31'd0, illegal}, 32'd0);
        chk("add_idle_ed", {26'd0, alu_ed}, {26'd0, ED_IDLE});
        consume();

        // sra $4,$5,4
        run({6'd0, 5'd0, 5'd5, 5'd4, 5'd4, 6'b000011}, 32'd0, 32'hFFFF0000, 6'b000011);
        chk("sra_edhold", {31'd0, ed_ok}, 32'd1);
        chk("sra_a", a_seen, 32'hFFFF0000);
        chk("sra_b", b_seen, 32'd4);
        chk("sra_data", res_data, 32'hFFFFF000);
        chk("sra_dst", {27'd0, res_dst}, 32'd4);
        consume();

        // addi $6,$1,-1
        run({6'b001000, 5'd1, 5'd6, 16'hFFFF}, 32'd10, 32'd0, 6'b110000);
        chk("addi_edhold", {31'd0, ed_ok}, 32'd1);
        chk("addi_b", b_seen, 32'hFFFFFFFF);
        chk("addi_data", res_data, 32'd9);
        chk("addi_dst", {27'd0, res_dst}, 32'd6);
        consume();

        // ori $7,$1,0xFFFF
        run({6'b001101, 5'd1, 5'd7, 16'hFFFF}, 32'h12340000, 32'd0, 6'b110011);
        chk("ori_edhold", {31'd0, ed_ok}, 32'd1);
        chk("ori_b", b_seen, 32'h0000FFFF);
        chk("ori_data", res_data, 32'h1234FFFF);
        consume();

        // beq $1,$2 with equal values
        run({6'b000100, 5'd1, 5'd2, 16'h0010}, 32'd3, 32'd3, 6'b111100);
        chk("beq_edhold", {31'd0, ed_ok}, 32'd1);
        chk("beq_kind", {30'd0, res_kind}, 32'd1);
        chk("beq_data", res_data, 32'd1);
        consume();

        // bltz $1 on a negative value
        run({6'b000001, 5'd1, 5'd0, 16'h0010}, 32'h80000000, 32'd0, 6'b111000);
        chk("bltz_edhold", {31'd0, ed_ok}, 32'd1);
        chk("bltz_data", res_data, 32'd1);
        chk("bltz_kind", {30'd0, res_kind}, 32'd1);
        consume();

        // lw $8,-4($1)
        run({6'b100011, 5'd1, 5'd8, 16'hFFFC}, 32'h00000100, 32'd0, 6'b110000);
        chk("lw_data", res_data, 32'h000000FC);
        chk("lw_kind", {30'd0, res_kind}, 32'd2);
        chk("lw_dst", {27'd0, res_dst}, 32'd8);
        consume();

        // illegal R-type funct 001111
        run({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001111}, 32'd1, 32'd2, ED_IDLE);
        chk("ill_lat", lat, 32'd1);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_kind", {30'd0, res_kind}, 32'd3);
        chk("ill_data", res_data, 32'd0);
        chk("ill_ed", {26'd0, alu_ed}, {26'd0, ED_IDLE});
        consume();
        chk("ill_clear", {31'd0, illegal}, 32'd0);

        // regimm with rt=2 and an unknown opcode are both illegal
        run({6'b000001, 5'd1, 5'd2, 16'd0}, 32'd1, 32'd0, ED_IDLE);
        chk("regimm_ill", {31'd0, illegal}, 32'd1);
        consume();
        run({6'b111111, 26'd0}, 32'd1, 32'd0, ED_IDLE);
        chk("opc_ill", {31'd0, illegal}, 32'd1);
        consume();

        // Back-pressure: result must stay put and new words must be refused
        run(32'h00221820, 32'd1, 32'd2, 6'b100000);
        instr = {6'b001000, 5'd1, 5'd6, 16'h0005};
        in_valid = 1'b1;
        flag = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 32'd3 || in_ready !== 1'b0) flag = 1'b0;
        end
        in_valid = 1'b0;
        chk("stall_stable", {31'd0, flag}, 32'd1);
        chk("stall_dst", {27'd0, res_dst}, 32'd3);
        consume();

        // Reset during HOLD drops the operation
        @(negedge clk);
        instr = 32'h00221820; rs_val = 32'd4; rt_val = 32'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("hrst_ready", {31'd0, in_ready}, 32'd1);
        chk("hrst_ed", {26'd0, alu_ed}, {26'd0, ED_IDLE});
        chk("hrst_a", alu_a, 32'd0);
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) flag = 1'b1;
        end
        chk("hrst_noresp", {31'd0, flag}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
